tlp_fifo_packer: RTL and testbench
==================================

Name: tlp_fifo_packer

Overview:
- Upstream feeder of the XGMII transmit engine, in the PCIe user clock domain.
- Accepts outbound TLPs from the PCIe core's 64-bit AXI-Stream interface and writes them into the TX FIFO in the 72-bit framed format that the transmit engine consumes.
- Guarantees that only whole, well-formed, bounded-length TLPs enter the FIFO.
- Keeps packet, drop and truncate statistics for the PCIe user registers.

Parameters:
- MAX_BEATS, 64: maximum 64-bit beats written per TLP; the beat counter is 8 bits wide; legal range 2..255.

Ports:
- pcie_clk  in  1  PCIe user clock; the only clock.
- sys_rst  in  1  reset, asynchronous, active-high.
- s_axis_tdata  in  64  TLP data; beat 0 bits [31:0] = header DW0.
- s_axis_tkeep  in  8  byte enables.
- s_axis_tlast  in  1  last beat of the TLP.
- s_axis_tvalid  in  1  source valid.
- s_axis_tready  out  1  sink ready.
- din  out  72  FIFO write word: b63-0 data, b64 start, b65 last, b66 low-DW enable, b67 high-DW enable, b68 IFG, b71-69 zero.
- wr_en  out  1  FIFO write strobe.
- prog_full  in  1  FIFO asserts this while free space < MAX_BEATS+1 words.
- pkt_cnt  out  32  TLPs fully written.
- drop_cnt  out  32  TLPs discarded.
- trunc_cnt  out  32  TLPs truncated at MAX_BEATS.

Behaviour:
- Handshake: a beat transfers when s_axis_tvalid & s_axis_tready are both high in the same cycle.
- Reset values: s_axis_tready=0, din=0, wr_en=0, all counters=0, state=IDLE. Reset mid-packet abandons the packet; no partial word is written after reset.
- Latency: din and wr_en are registered; a write appears one cycle after its handshake. wr_en is deasserted in every cycle with no handshake.
- Encoding:
  - b66 = |tkeep[3:0]; b67 = |tkeep[7:4].
  - b68 = 1 only on the last word of a TLP.
  - b64 = 1 only on the first word; b65 = 1 only on the last word.
  - b64 & b65 are never both set.
- State IDLE:
  - s_axis_tready = ~prog_full.
  - On beat 0 with tlast=1 (single-beat): no write, drop_cnt+1, stay in IDLE.
  - On beat 0 that the filter rejects: no write, drop_cnt+1; go to DROP, or stay in IDLE if tlast.
  - Otherwise: write the beat with b64=1, set beat_cnt=1, go to PASS.
- State PASS:
  - s_axis_tready = 1. FIFO room is already guaranteed by prog_full being low at admission, so prog_full is ignored here.
  - Each beat is written and beat_cnt increments.
  - On tlast: write with b65=1, pkt_cnt+1, go to IDLE.
  - If the beat makes beat_cnt == MAX_BEATS without tlast: write with b65=1, trunc_cnt+1, go to DROP.
  - If the beat reaching MAX_BEATS also carries tlast: the packet is normal; pkt_cnt+1, trunc_cnt unchanged.
- State DROP: s_axis_tready = 1; consume beats without writing; on tlast go to IDLE.
- Counters wrap 0xFFFFFFFF -> 0. At most one counter increments per cycle.
- prog_full rising during PASS does not stall the packet. prog_full high in IDLE holds s_axis_tready=0; the source's tvalid may stay high and nothing is lost.

Optional Feature:
- Macro: TLP_FILTER_MWR_EN.
- Defined: beat 0 passes only when DW0[30:29] is 2'b10 or 2'b11 and DW0[28:24] == 5'b00000 (memory write, 3DW or 4DW). All other TLPs follow the reject path to DROP and count in drop_cnt.
- Undefined: every multi-beat TLP passes; the filter logic is absent.

Decomposition:
- Shared package, with the transmit engine, holds:
  - FIFO bit-position constants: start=64, last=65, lo_en=66, hi_en=67, ifg=68.
  - FIFO width 72.
  - State encodings IDLE/PASS/DROP.
  - TLP fmt/type constants.
- No sub-module. The filter is a small function or inline compare inside the block.

Test Plan:
- 3-beat MWr with tkeep ff/ff/0f and prog_full=0 -> three writes with b64 on word 0, b65+b68 on word 2, word 2 b67=0; pkt_cnt=1.
- Single-beat TLP with tlast on beat 0 -> no wr_en; drop_cnt=1; s_axis_tready stays 1.
- prog_full=1 in IDLE with tvalid held for 10 cycles, then prog_full=0 -> s_axis_tready=0 throughout, no writes; the packet is then written intact. prog_full rising mid-PASS -> no stall.
- 70-beat packet with MAX_BEATS=64 -> 64 writes, word 63 has b65=1; beats 64..69 consumed without writes; trunc_cnt=1, pkt_cnt=0.
- TLP_FILTER_MWR_EN defined, MRd DW0=0x00000001 (4 beats) -> no writes, drop_cnt=1. Following MWr DW0=0x40000001 -> written normally.
- sys_rst asserted at beat 2 of 5 -> wr_en=0 immediately, counters cleared. After release, the next TLP is written starting with b64=1.

Source files
------------

// File: rtl/tlp_fifo_packer_pkg.sv
// Shared definitions for the TX FIFO word format, packer state encoding and
// the TLP fmt/type fields used by the optional memory-write filter.
package tlp_fifo_packer_pkg;

  // 72-bit TX FIFO word layout consumed by the XGMII transmit engine
  localparam int unsigned FifoWidth    = 72;
  localparam int unsigned FifoStartBit = 64;
  localparam int unsigned FifoLastBit  = 65;
  localparam int unsigned FifoLoEnBit  = 66;
  localparam int unsigned FifoHiEnBit  = 67;
  localparam int unsigned FifoIfgBit   = 68;

  // Packer states: IDLE / PASS / DROP
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StPass = 2'd1,
    StDrop = 2'd2
  } state_e;

  // TLP header DW0 fmt[30:29] and type[28:24] values
  localparam logic [1:0] TlpFmt3dwData = 2'b10;
  localparam logic [1:0] TlpFmt4dwData = 2'b11;
  localparam logic [4:0] TlpTypeMem    = 5'b00000;

endpackage

// File: rtl/tlp_fifo_packer.sv
// Packs outbound 64-bit AXI-Stream TLPs into 72-bit framed TX FIFO words.
// Only whole multi-beat TLPs of at most MAX_BEATS words are written; longer
// ones are cut at MAX_BEATS and the remainder discarded.
// Build option: define TLP_FILTER_MWR_EN to admit only memory-write TLPs.
module tlp_fifo_packer
  import tlp_fifo_packer_pkg::*;
#(
  parameter int unsigned MAX_BEATS = 64
) (
  input  logic                 pcie_clk,
  input  logic                 sys_rst,
  input  logic [63:0]          s_axis_tdata,
  input  logic [7:0]           s_axis_tkeep,
  input  logic                 s_axis_tlast,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  output logic [FifoWidth-1:0] din,
  output logic                 wr_en,
  input  logic                 prog_full,
  output logic [31:0]          pkt_cnt,
  output logic [31:0]          drop_cnt,
  output logic [31:0]          trunc_cnt
);

  state_e                 state_q, state_d;
  logic [7:0]             beat_q, beat_d;
  logic [FifoWidth-1:0]   din_q, din_d;
  logic                   wr_en_q, wr_en_d;
  logic [31:0]            pkt_q, pkt_d, drop_q, drop_d, trunc_q, trunc_d;
  logic                   ready_c, hs, filter_pass;
  logic [7:0]             beat_inc;
  logic [7:0]             max_beats;

  assign max_beats = 8'(MAX_BEATS);
  assign beat_inc  = beat_q + 8'd1;

`ifdef TLP_FILTER_MWR_EN
  // Memory write, 3DW or 4DW header with data
  function automatic logic is_mem_write(input logic [31:0] dw0);
    return ((dw0[30:29] == TlpFmt3dwData) || (dw0[30:29] == TlpFmt4dwData)) &&
           (dw0[28:24] == TlpTypeMem);
  endfunction
  assign filter_pass = is_mem_write(s_axis_tdata[31:0]);
`else
  assign filter_pass = 1'b1;
`endif

  // Ready is held low while in reset so nothing handshakes before the FSM runs
  assign s_axis_tready = ready_c & ~sys_rst;
  assign hs            = s_axis_tvalid & ready_c;

  // Next-state, FIFO word formatting and counter updates
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    din_d   = '0;
    din_d[63:0]        = s_axis_tdata;
    din_d[FifoLoEnBit] = |s_axis_tkeep[3:0];
    din_d[FifoHiEnBit] = |s_axis_tkeep[7:4];
    wr_en_d = 1'b0;
    pkt_d   = pkt_q;
    drop_d  = drop_q;
    trunc_d = trunc_q;
    ready_c = 1'b1;
    unique case (state_q)
      StIdle: begin
        // Admission needs room for a full MAX_BEATS packet; PASS never stalls
        ready_c = ~prog_full;
        if (hs) begin
          if (s_axis_tlast || !filter_pass) begin
            drop_d = drop_q + 32'd1;
            if (!s_axis_tlast) state_d = StDrop;
          end else begin
            wr_en_d             = 1'b1;
            din_d[FifoStartBit] = 1'b1;
            beat_d              = 8'd1;
            state_d             = StPass;
          end
        end
      end
      StPass: begin
        if (hs) begin
          wr_en_d = 1'b1;
          beat_d  = beat_inc;
          if (s_axis_tlast) begin
            din_d[FifoLastBit] = 1'b1;
            din_d[FifoIfgBit]  = 1'b1;
            pkt_d              = pkt_q + 32'd1;
            state_d            = StIdle;
          end else if (beat_inc == max_beats) begin
            // Close the frame here and swallow the rest of the TLP
            din_d[FifoLastBit] = 1'b1;
            din_d[FifoIfgBit]  = 1'b1;
            trunc_d            = trunc_q + 32'd1;
            state_d            = StDrop;
          end
        end
      end
      StDrop: begin
        if (hs && s_axis_tlast) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State, registered FIFO write port and statistics
  always_ff @(posedge pcie_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= StIdle;
      beat_q  <= '0;
      din_q   <= '0;
      wr_en_q <= 1'b0;
      pkt_q   <= '0;
      drop_q  <= '0;
      trunc_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      din_q   <= din_d;
      wr_en_q <= wr_en_d;
      pkt_q   <= pkt_d;
      drop_q  <= drop_d;
      trunc_q <= trunc_d;
    end
  end

  assign din       = din_q;
  assign wr_en     = wr_en_q;
  assign pkt_cnt   = pkt_q;
  assign drop_cnt  = drop_q;
  assign trunc_cnt = trunc_q;

endmodule

// File: tb/tb_tlp_fifo_packer.sv
// Self-checking bench for tlp_fifo_packer: directed and random TLPs are
// predicted packet-by-packet into an expected FIFO word queue and counters.
// Honours TLP_FILTER_MWR_EN in its reference model.
module tb_tlp_fifo_packer;

  localparam int unsigned MaxBeats = 64;

  logic        pcie_clk = 1'b0;
  logic        sys_rst;
  logic [63:0] s_axis_tdata;
  logic [7:0]  s_axis_tkeep;
  logic        s_axis_tlast;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [71:0] din;
  logic        wr_en;
  logic        prog_full;
  logic [31:0] pkt_cnt, drop_cnt, trunc_cnt;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [71:0] exp_q[$];
  logic [31:0] e_pkt = 0, e_drop = 0, e_trunc = 0;

  tlp_fifo_packer #(.MAX_BEATS(MaxBeats)) dut (
    .pcie_clk      (pcie_clk),
    .sys_rst       (sys_rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .din           (din),
    .wr_en         (wr_en),
    .prog_full     (prog_full),
    .pkt_cnt       (pkt_cnt),
    .drop_cnt      (drop_cnt),
    .trunc_cnt     (trunc_cnt)
  );

  always #5 pcie_clk = ~pcie_clk;

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Reference filter: fmt/type byte must be 0x40 (3DW MWr) or 0x60 (4DW MWr)
  function automatic bit ref_pass(input logic [31:0] dw0);
`ifdef TLP_FILTER_MWR_EN
    logic [7:0] ft;
    ft = dw0[31:24] & 8'h7F;
    return (ft == 8'h40) || (ft == 8'h60);
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [71:0] mk_word(input logic [63:0] d, input logic [7:0] k,
                                          input bit first, input bit last);
    return {3'b000, last, |k[7:4], |k[3:0], last, first, d};
  endfunction

  // Scoreboard: every FIFO write must match the next predicted word
  always @(negedge pcie_clk) begin
    if (!sys_rst && wr_en === 1'b1) begin
      if (exp_q.size() == 0) check("spurious_wr_en", {71'b0, wr_en}, 72'b0);
      else check("fifo_word", din, exp_q.pop_front());
    end
  end

  task automatic put_beat(input logic [63:0] d, input logic [7:0] k, input bit last);
    int t = 0;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    forever begin
      @(negedge pcie_clk);
      if (s_axis_tready === 1'b1) break;
      t++;
      if (t > 200) begin
        $display("FAIL handshake_timeout: observed tready=%b expected 1", s_axis_tready);
        $fatal(1, "handshake timeout");
      end
    end
    @(posedge pcie_clk);
    #1;
    s_axis_tvalid = 1'b0;
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_pkt"},   {40'b0, pkt_cnt},   {40'b0, e_pkt});
    check({tag, "_drop"},  {40'b0, drop_cnt},  {40'b0, e_drop});
    check({tag, "_trunc"}, {40'b0, trunc_cnt}, {40'b0, e_trunc});
  endtask

  // Drive one TLP of n beats; last_keep==0 picks a random last-beat keep
  task automatic send_pkt(input int n, input logic [31:0] dw0, input logic [7:0] last_keep,
                          input bit pf_hold, input bit pf_mid);
    logic [63:0] d[$];
    logic [7:0]  k[$];
    int nw;
    for (int i = 0; i < n; i++) begin
      logic [63:0] dd;
      logic [7:0]  kk;
      dd = {$urandom(), $urandom()};
      if (i == 0) dd[31:0] = dw0;
      kk = 8'hFF;
      if (i == n - 1) kk = (last_keep != 0) ? last_keep : (($urandom_range(0, 1) != 0) ? 8'h0F : 8'hFF);
      d.push_back(dd);
      k.push_back(kk);
    end
    if (n == 1 || !ref_pass(dw0)) begin
      nw = 0;
      e_drop++;
    end else if (n > int'(MaxBeats)) begin
      nw = MaxBeats;
      e_trunc++;
    end else begin
      nw = n;
      e_pkt++;
    end
    if (pf_hold) begin
      prog_full     = 1'b1;
      s_axis_tdata  = d[0];
      s_axis_tkeep  = k[0];
      s_axis_tlast  = (n == 1);
      s_axis_tvalid = 1'b1;
      for (int c = 0; c < 10; c++) begin
        @(negedge pcie_clk);
        check("pf_hold_tready", {71'b0, s_axis_tready}, 72'b0);
      end
      @(posedge pcie_clk);
      #1;
      prog_full = 1'b0;
    end
    for (int i = 0; i < nw; i++) exp_q.push_back(mk_word(d[i], k[i], i == 0, i == nw - 1));
    for (int i = 0; i < n; i++) begin
      put_beat(d[i], k[i], i == n - 1);
      if (pf_mid && i == 0) prog_full = 1'b1;
      if ($urandom_range(0, 3) == 0) begin
        @(posedge pcie_clk);
        #1;
      end
    end
    prog_full = 1'b0;
    repeat (3) @(posedge pcie_clk);
    #1;
    check("queue_drained", 72'(exp_q.size()), 72'd0);
    check_counters("pkt_end");
  endtask

  initial begin
    sys_rst       = 1'b1;
    prog_full     = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tlast  = 1'b0;
    s_axis_tvalid = 1'b0;
    @(negedge pcie_clk);
    check("rst_tready", {71'b0, s_axis_tready}, 72'b0);
    check("rst_wr_en",  {71'b0, wr_en}, 72'b0);
    check("rst_din",    din, 72'b0);
    check_counters("rst");
    @(posedge pcie_clk);
    #1;
    sys_rst = 1'b0;

    // 3-beat MWr, keep ff/ff/0f
    send_pkt(3, 32'h4000_0001, 8'h0F, 1'b0, 1'b0);
    // Single-beat TLP is dropped, sink stays ready
    send_pkt(1, 32'h4000_0001, 8'hFF, 1'b0, 1'b0);
    @(negedge pcie_clk);
    check("single_tready", {71'b0, s_axis_tready}, 72'd1);
    // Back-pressure in IDLE, then prog_full rising mid-packet
    send_pkt(5, 32'h6000_0010, 8'h0, 1'b1, 1'b0);
    send_pkt(8, 32'h4000_0004, 8'h0, 1'b0, 1'b1);
    // Length boundaries around MAX_BEATS
    send_pkt(70, 32'h4000_0040, 8'h0, 1'b0, 1'b0);
    send_pkt(int'(MaxBeats), 32'h4000_0040, 8'h0, 1'b0, 1'b0);
    send_pkt(int'(MaxBeats) + 1, 32'h6000_0040, 8'h0, 1'b0, 1'b0);
    send_pkt(2, 32'h4000_0001, 8'h0, 1'b0, 1'b0);
    // MRd then MWr (filtered only when the feature is built in)
    send_pkt(4, 32'h0000_0001, 8'h0, 1'b0, 1'b0);
    send_pkt(4, 32'h4000_0001, 8'h0, 1'b0, 1'b0);

    // Random TLPs with a mix of fmt/type codes and lengths
    for (int p = 0; p < 20; p++) begin
      logic [7:0]  ft;
      logic [31:0] dw;
      int sel;
      sel = $urandom_range(0, 5);
      case (sel)
        0: ft = 8'h40;
        1: ft = 8'h60;
        2: ft = 8'h00;
        3: ft = 8'h20;
        4: ft = 8'h4A;
        default: ft = 8'hF4;
      endcase
      dw = {ft, 24'($urandom())};
      send_pkt($urandom_range(1, 70), dw, 8'h0, $urandom_range(0, 4) == 0,
               $urandom_range(0, 2) == 0);
    end

    // Reset in the middle of a 5-beat packet: only beat 0 is observed
    exp_q.push_back(mk_word({32'h1234_5678, 32'h4000_0005}, 8'hFF, 1'b1, 1'b0));
    put_beat({32'h1234_5678, 32'h4000_0005}, 8'hFF, 1'b0);
    s_axis_tdata  = 64'hDEAD_BEEF_0000_0001;
    s_axis_tkeep  = 8'hFF;
    s_axis_tlast  = 1'b0;
    s_axis_tvalid = 1'b1;
    @(negedge pcie_clk);
    @(posedge pcie_clk);
    #1;
    sys_rst       = 1'b1;
    s_axis_tvalid = 1'b0;
    e_pkt   = 0;
    e_drop  = 0;
    e_trunc = 0;
    @(negedge pcie_clk);
    check("midrst_wr_en",  {71'b0, wr_en}, 72'b0);
    check("midrst_tready", {71'b0, s_axis_tready}, 72'b0);
    check("midrst_queue",  72'(exp_q.size()), 72'd0);
    check_counters("midrst");
    @(posedge pcie_clk);
    #1;
    sys_rst = 1'b0;
    send_pkt(4, 32'h4000_0002, 8'h0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
